vec_to_idx_encoder: RTL and testbench

- Sequential encoder for the select path: the inverse of our 3-to-8 one-hot decoder.
- Accepts an 8-bit request vector (any number of bits set) over a valid/ready handshake.
- Emits one 3-bit index per set bit, lowest index first, over a second valid/ready handshake.
- Sits between request/interrupt sources and any consumer that re-expands indices through the 3-to-8 decoder.

---
 rtl/enc_pkg.sv | 24 ++
 rtl/prio_enc_8to3.sv | 38 +++
 rtl/vec_to_idx_encoder.sv | 137 +++++++++++++
 tb/tb_vec_to_idx_encoder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enc_pkg
// Description : Shared sizes and types for the vector-to-index encoder.
//               N_IN  - request vector width (power of two, >= 2)
//               IDX_W - index width, derived from N_IN
//               enc_state_t - encoder control states (IDLE, EMIT)
// Revision    : 1.0 - initial release
// ============================================================================
package enc_pkg;

    localparam int N_IN  = 8;
    localparam int IDX_W = $clog2(N_IN);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } enc_state_t;

    typedef logic [N_IN-1:0]  req_vec_t;
    typedef logic [IDX_W-1:0] idx_t;

endpackage : enc_pkg
`default_nettype wire

// File: rtl/prio_enc_8to3.sv
`default_nettype none
// ============================================================================
// Module      : prio_enc_8to3
// Description : Combinational lowest-set-bit finder.
// Ports       : vec    in  N_IN   vector to scan
//               idx    out IDX_W  index of the lowest set bit (0 if none)
//               any    out 1      at least one bit set
//               single out 1      exactly one bit set
// Revision    : 1.0 - initial release
// ============================================================================
module prio_enc_8to3 #(
    parameter int N_IN  = 8,
    parameter int IDX_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  vec,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             single
);

    localparam logic [N_IN-1:0] c_ONE = {{(N_IN-1){1'b0}}, 1'b1};

    // Scanning from the top down lets the lowest set bit overwrite last.
    always_comb begin
        idx = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any    = |vec;
    // Clearing the lowest set bit leaves zero only if it was the only one.
    assign single = any && ((vec & (vec - c_ONE)) == '0);

endmodule : prio_enc_8to3
`default_nettype wire

// File: rtl/vec_to_idx_encoder.sv
`default_nettype none
// ============================================================================
// Module      : vec_to_idx_encoder
// Description : Sequential encoder: accepts a request vector and emits one
//               index per set bit, lowest first, over a valid/ready pair.
//               Optional macro ENC_PIPE_EN lets a new vector be accepted on
//               the final index handshake so vectors stream with no bubble.
// Ports       : clk        in  1      clock, rising edge
//               rst        in  1      asynchronous active-high reset
//               in_valid   in  1      request vector valid
//               in_ready   out 1      block can accept a vector
//               in_vec     in  N_IN   request vector
//               out_valid  out 1      out_idx valid
//               out_ready  in  1      consumer accepts out_idx
//               out_idx    out IDX_W  lowest set bit of pending vector
//               out_last   out 1      current index is the final one
//               zero_pulse out 1      one-cycle pulse on all-zero accept
//               busy       out 1      high while in EMIT
// Revision    : 1.0 - initial release
// ============================================================================
module vec_to_idx_encoder
    import enc_pkg::*;
#(
    parameter int N_IN = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_IN-1:0]         in_vec,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(N_IN)-1:0] out_idx,
    output logic                    out_last,
    output logic                    zero_pulse,
    output logic                    busy
);

    localparam int              IDX_W = $clog2(N_IN);
    localparam logic [N_IN-1:0] c_ONE = {{(N_IN-1){1'b0}}, 1'b1};

    generate
        if ((N_IN < 2) || ((N_IN & (N_IN - 1)) != 0)) begin : g_bad_width
            $error("vec_to_idx_encoder: N_IN must be a power of two >= 2");
        end
    endgenerate

    enc_state_t       r_state;
    logic [N_IN-1:0]  r_pend;
    logic             r_zero_pulse;
    // Holds in_ready low until the first clock edge after reset releases.
    logic             r_run;

    logic [IDX_W-1:0] w_idx;
    logic             w_any;
    logic             w_last;
    logic             w_out_valid;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_out_hs;
    logic             w_vec_zero;

    prio_enc_8to3 #(
        .N_IN  (N_IN),
        .IDX_W (IDX_W)
    ) u_prio (
        .vec    (r_pend),
        .idx    (w_idx),
        .any    (w_any),
        .single (w_last)
    );

    assign w_out_valid = (r_state == EMIT);

`ifdef ENC_PIPE_EN
    // Accepting on the last handshake removes the dead cycle between vectors.
    assign w_in_ready = r_run &&
                        ((r_state == IDLE) ||
                         ((r_state == EMIT) && w_last && out_ready));
`else
    assign w_in_ready = r_run && (r_state == IDLE);
`endif

    assign w_accept   = in_valid && w_in_ready;
    assign w_out_hs   = w_out_valid && out_ready;
    assign w_vec_zero = (in_vec == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pend       <= '0;
            r_zero_pulse <= 1'b0;
            r_run        <= 1'b0;
        end else begin
            r_run        <= 1'b1;
            r_zero_pulse <= w_accept && w_vec_zero;
            case (r_state)
                IDLE: begin
                    if (w_accept && !w_vec_zero) begin
                        r_pend  <= in_vec;
                        r_state <= EMIT;
                    end
                end
                EMIT: begin
                    if (w_out_hs) begin
                        // Drop the bit just handed out.
                        r_pend <= r_pend & (r_pend - c_ONE);
                        if (w_last || !w_any) begin
`ifdef ENC_PIPE_EN
                            if (w_accept && !w_vec_zero) begin
                                r_pend  <= in_vec;
                                r_state <= EMIT;
                            end else begin
                                r_state <= IDLE;
                            end
`else
                            r_state <= IDLE;
`endif
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign out_idx    = w_idx;
    assign out_last   = w_last;
    assign zero_pulse = r_zero_pulse;
    assign busy       = w_out_valid;

endmodule : vec_to_idx_encoder
`default_nettype wire

// File: tb/tb_vec_to_idx_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_vec_to_idx_encoder
// Description : Directed and round-trip checks for vec_to_idx_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_to_idx_encoder;

    localparam int N_VEC = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_vec;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_idx;
    logic       out_last;
    logic       zero_pulse;
    logic       busy;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    vec_to_idx_encoder #(.N_IN(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec     (in_vec),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .zero_pulse (zero_pulse),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] dec3to8(input logic [2:0] idx);
        logic [7:0] one;
        one = 8'h01;
        return one << idx;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] vecs [N_VEC];
        logic [7:0] expq [$];
        logic [7:0] recon;
        logic [7:0] expv;
        int         sent, done, cycles, exp_cycles, kbits;
        logic       acc_now, hs_now, last_now, prev_nonzero;
        logic [2:0] idx_now;

        // ---------------- reset with FF presented ----------------
        rst = 1'b1; in_valid = 1'b1; in_vec = 8'hFF; out_ready = 1'b1;
        step(); step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_zero_pulse", {31'd0, zero_pulse}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        step();
        in_valid = 1'b0;
        chk("ff_in_ready_emit", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("ff_valid", {31'd0, out_valid}, 32'd1);
            chk("ff_idx", {29'd0, out_idx}, i);
            chk("ff_last", {31'd0, out_last}, (i == 7) ? 32'd1 : 32'd0);
            step();
        end
        chk("ff_done_valid", {31'd0, out_valid}, 32'd0);
        chk("ff_done_ready", {31'd0, in_ready}, 32'd1);

        // ---------------- 1010_0100, no backpressure ----------------
        in_valid = 1'b1; in_vec = 8'b1010_0100;
        step();
        in_valid = 1'b0;
        chk("a4_busy", {31'd0, busy}, 32'd1);
        chk("a4_idx0", {29'd0, out_idx}, 32'd2);
        chk("a4_last0", {31'd0, out_last}, 32'd0);
        step();
        chk("a4_idx1", {29'd0, out_idx}, 32'd5);
        chk("a4_last1", {31'd0, out_last}, 32'd0);
        step();
        chk("a4_idx2", {29'd0, out_idx}, 32'd7);
        chk("a4_last2", {31'd0, out_last}, 32'd1);
        step();
        chk("a4_idle_valid", {31'd0, out_valid}, 32'd0);
        chk("a4_idle_busy", {31'd0, busy}, 32'd0);

        // ---------------- backpressure 1,0,0,1,1 ----------------
        in_valid = 1'b1; in_vec = 8'b1010_0100;
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_c1_idx", {29'd0, out_idx}, 32'd2);
        step();
        out_ready = 1'b0;
        chk("bp_c2_idx", {29'd0, out_idx}, 32'd5);
        step();
        chk("bp_c3_idx", {29'd0, out_idx}, 32'd5);
        chk("bp_c3_valid", {31'd0, out_valid}, 32'd1);
        step();
        out_ready = 1'b1;
        chk("bp_c4_idx", {29'd0, out_idx}, 32'd5);
        step();
        chk("bp_c5_idx", {29'd0, out_idx}, 32'd7);
        chk("bp_c5_last", {31'd0, out_last}, 32'd1);
        step();
        chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);

        // ---------------- all-zero vector ----------------
        in_valid = 1'b1; in_vec = 8'h00;
        chk("zero_pre_pulse", {31'd0, zero_pulse}, 32'd0);
        step();
        in_valid = 1'b0;
        chk("zero_pulse_hi", {31'd0, zero_pulse}, 32'd1);
        chk("zero_out_valid", {31'd0, out_valid}, 32'd0);
        chk("zero_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("zero_pulse_lo", {31'd0, zero_pulse}, 32'd0);
        chk("zero_out_valid2", {31'd0, out_valid}, 32'd0);

        // ---------------- reset mid-vector ----------------
        in_valid = 1'b1; in_vec = 8'b1010_0100;
        step();
        in_valid = 1'b0;
        chk("mid_idx_first", {29'd0, out_idx}, 32'd2);
        step();
        chk("mid_idx_second", {29'd0, out_idx}, 32'd5);
        rst = 1'b1;
        #1;
        chk("mid_async_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_async_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("mid_post_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_post_valid", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1; in_vec = 8'h10;
        step();
        in_valid = 1'b0;
        chk("mid_10_idx", {29'd0, out_idx}, 32'd4);
        chk("mid_10_last", {31'd0, out_last}, 32'd1);
        step();
        chk("mid_10_done", {31'd0, out_valid}, 32'd0);

        // ---------------- round-trip with in_valid held high ----------------
        for (int i = 0; i < N_VEC; i++) begin
            if (i % 37 == 5)       vecs[i] = 8'h00;
            else if (i % 41 == 7)  vecs[i] = 8'hFF;
            else                   vecs[i] = 8'($urandom_range(0, 255));
        end
        exp_cycles   = 0;
        prev_nonzero = 1'b0;
        for (int i = 0; i < N_VEC; i++) begin
            kbits = $countones(vecs[i]);
`ifdef ENC_PIPE_EN
            exp_cycles += kbits + (prev_nonzero ? 0 : 1);
`else
            exp_cycles += kbits + 1;
`endif
            prev_nonzero = (vecs[i] != 8'h00);
        end

        sent = 0; done = 0; cycles = 0; recon = 8'h00;
        out_ready = 1'b1;
        while (done < N_VEC && cycles < 20000) begin
            @(negedge clk);
            in_valid = (sent < N_VEC);
            in_vec   = (sent < N_VEC) ? vecs[sent] : 8'h00;
            #1;
            acc_now  = in_valid && in_ready;
            hs_now   = out_valid && out_ready;
            idx_now  = out_idx;
            last_now = out_last;
            @(posedge clk);
            cycles++;
            if (hs_now) begin
                recon = recon | dec3to8(idx_now);
                if (last_now) begin
                    expv = (expq.size() > 0) ? expq.pop_front() : 8'hxx;
                    chk("roundtrip_vec", {24'd0, recon}, {24'd0, expv});
                    recon = 8'h00;
                    done++;
                end
            end
            if (acc_now) begin
                if (vecs[sent] == 8'h00) done++;
                else expq.push_back(vecs[sent]);
                sent++;
            end
        end
        in_valid = 1'b0;
        chk("roundtrip_all_done", done, N_VEC);
        chk("roundtrip_cycles", cycles, exp_cycles);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_vec_to_idx_encoder
`default_nettype wire
